// File: rtl/dram_multiport_pkg.sv
// Shared types and helpers for the multi-port distributed-RAM block.
// The optional parity store is enabled with DRAM_MULTIPORT_PARITY_EN.
package dram_multiport_pkg;

    // Clear sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Widest data word the parity helper covers
    localparam int unsigned PAR_MAX_W = 32;

    // Even-parity bit: makes the total count of ones in {par, data} even
    function automatic logic par_even(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dram_multiport_clear_seq.sv
// Clear sequencer: walks every address once after reset or on request,
// asserting clr_we_o and holding busy_o high for the whole sweep.
module dram_multiport_clear_seq
    import dram_multiport_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // State, counter and busy flag; reset starts a sweep from address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: sweep until the last address is written, requests ignored mid-sweep
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dram_multiport.sv
// Multi-port LUT-RAM: one write port, NUM_RD registered read ports,
// write-first bypass on collision and a built-in clear sweep.
// Define DRAM_MULTIPORT_PARITY_EN to store an even-parity bit per word
// and report mismatches on rd_perr.
module dram_multiport
    import dram_multiport_pkg::*;
#(
    parameter int unsigned       DATA_W    = 4,
    parameter int unsigned       ADDR_W    = 6,
    parameter int unsigned       NUM_RD    = 3,
    parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
`ifdef DRAM_MULTIPORT_PARITY_EN
    output logic [NUM_RD-1:0]        rd_perr,
`endif
    input  logic                     clear_req,
    output logic                     busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef DRAM_MULTIPORT_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MEM_W-1:0]  mem_wword;

    logic [NUM_RD*DATA_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0]        rd_a;
    logic [MEM_W-1:0]         rd_word;
`ifdef DRAM_MULTIPORT_PARITY_EN
    logic [NUM_RD-1:0]        perr_q, perr_d;
`endif

    dram_multiport_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .clear_req_i (clear_req),
        .busy_o      (busy),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    // Write mux: the clear sweep owns the port while busy, user writes otherwise
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (busy) begin
            mem_we    = clr_we;
            mem_waddr = clr_addr;
            mem_wdata = CLEAR_VAL;
        end else begin
            mem_we    = wr_en;
        end
`ifdef DRAM_MULTIPORT_PARITY_EN
        mem_wword = {par_even(PAR_MAX_W'(mem_wdata)), mem_wdata};
`else
        mem_wword = mem_wdata;
`endif
    end

    // LUT-RAM array; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wword;
        end
    end

    // Read ports: async array read with write-first bypass, forced to 0 while busy
    always_comb begin
        rd_d    = '0;
        rd_a    = '0;
        rd_word = '0;
`ifdef DRAM_MULTIPORT_PARITY_EN
        perr_d  = '0;
`endif
        if (!busy) begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_a    = rd_addr[k*ADDR_W +: ADDR_W];
                rd_word = mem_q[rd_a];
                if (wr_en && (rd_a == wr_addr)) begin
                    rd_d[k*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_d[k*DATA_W +: DATA_W] = rd_word[DATA_W-1:0];
`ifdef DRAM_MULTIPORT_PARITY_EN
                    perr_d[k] = rd_word[DATA_W] ^ par_even(PAR_MAX_W'(rd_word[DATA_W-1:0]));
`endif
                end
            end
        end
    end

    // Read output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
`ifdef DRAM_MULTIPORT_PARITY_EN
            perr_q <= '0;
`endif
        end else begin
            rd_q   <= rd_d;
`ifdef DRAM_MULTIPORT_PARITY_EN
            perr_q <= perr_d;
`endif
        end
    end

    assign rd_data = rd_q;
`ifdef DRAM_MULTIPORT_PARITY_EN
    assign rd_perr = perr_q;
`endif

endmodule

// File: tb/tb_dram_multiport.sv
// Self-checking bench for dram_multiport: vector table, random traffic
// against an array model, and hand-written clear/reset sequences.
module tb_dram_multiport;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NUM_RD = 3;
    localparam int unsigned DEPTH  = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     clear_req;
    logic                     busy;
`ifdef DRAM_MULTIPORT_PARITY_EN
    logic [NUM_RD-1:0]        rd_perr;
`endif

    always #5 clk = ~clk;

    dram_multiport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
`ifdef DRAM_MULTIPORT_PARITY_EN
        .rd_perr   (rd_perr),
`endif
        .clear_req (clear_req),
        .busy      (busy)
    );

    typedef struct {
        logic                     we;
        logic [ADDR_W-1:0]        wa;
        logic [DATA_W-1:0]        wd;
        logic [NUM_RD*ADDR_W-1:0] ra;
        logic [NUM_RD*DATA_W-1:0] exp;
    } vec_t;

    vec_t             tbl [8];
    logic [DATA_W-1:0] mdl [DEPTH];
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [NUM_RD*ADDR_W-1:0] ra, input logic cr);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr   = ra;
        clear_req = cr;
    endtask

    // Counts edges until busy is seen low, bounded
    task automatic count_busy(output int n, output logic rd_nonzero);
        n          = 0;
        rd_nonzero = 1'b0;
        do begin
            tick();
            n++;
            if (busy && rd_data != '0) rd_nonzero = 1'b1;
        end while (busy && n < 500);
    endtask

    // Expected read for one port given the current model and write inputs
    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (wr_en && a == wr_addr) return wr_data;
        return mdl[a];
    endfunction

    initial begin
        int   n;
        logic bad;
        logic [NUM_RD*DATA_W-1:0] e;
        logic [ADDR_W-1:0] a;

        tbl[0] = '{1'b0, 6'd0,  4'h0, {6'd63, 6'd31, 6'd0}, 12'h000};
        tbl[1] = '{1'b1, 6'd5,  4'hA, {6'd0,  6'd0,  6'd0}, 12'h000};
        tbl[2] = '{1'b1, 6'd63, 4'h3, {6'd1,  6'd1,  6'd1}, 12'h000};
        tbl[3] = '{1'b0, 6'd0,  4'h0, {6'd63, 6'd5,  6'd5}, 12'h3AA};
        tbl[4] = '{1'b1, 6'd13, 4'h1, {6'd0,  6'd0,  6'd0}, 12'h000};
        tbl[5] = '{1'b1, 6'd12, 4'h7, {6'd12, 6'd13, 6'd12}, 12'h717};
        tbl[6] = '{1'b0, 6'd0,  4'h0, {6'd13, 6'd12, 6'd12}, 12'h177};
        tbl[7] = '{1'b1, 6'd20, 4'hF, {6'd20, 6'd20, 6'd20}, 12'hFFF};

        rst = 1'b1;
        drive(1'b0, '0, '0, {6'd63, 6'd31, 6'd0}, 1'b0);
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rd_data", 32'(rd_data), 32'd0);

        // Power-up clear
        rst = 1'b0;
        count_busy(n, bad);
        check("init_clear_cycles", 32'(n), 32'd64);
        check("init_rd_zero_while_busy", 32'(bad), 32'd0);
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        tick();
        check("init_read_0_31_63", 32'(rd_data), 32'd0);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, 1'b0);
            tick();
            check($sformatf("vec%0d", i), 32'(rd_data), 32'(tbl[i].exp));
            if (tbl[i].we) mdl[tbl[i].wa] = tbl[i].wd;
        end

        // Random traffic against the array model
        for (int c = 0; c < 300; c++) begin
            logic [NUM_RD*ADDR_W-1:0] ra;
            logic [ADDR_W-1:0] wa;
            wa = ADDR_W'($urandom_range(0, DEPTH - 1));
            for (int k = 0; k < NUM_RD; k++)
                ra[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom_range(0, 1)), wa, DATA_W'($urandom_range(0, 15)), ra, 1'b0);
            for (int k = 0; k < NUM_RD; k++) e[k*DATA_W +: DATA_W] = exp_rd(ra[k*ADDR_W +: ADDR_W]);
            tick();
            check($sformatf("rand%0d", c), 32'(rd_data), 32'(e));
            if (wr_en) mdl[wr_addr] = wr_data;
        end

        // Fill, then request a clear with a same-cycle write
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, ADDR_W'(i), DATA_W'(i) ^ 4'h5, '0, 1'b0);
            tick();
        end
        drive(1'b1, 6'd2, 4'hC, {6'd5, 6'd5, 6'd5}, 1'b1);
        tick();
        check("clear_req_busy_rise", 32'(busy), 32'd1);
        drive(1'b1, 6'd9, 4'hF, {6'd9, 6'd9, 6'd9}, 1'b1);
        count_busy(n, bad);
        check("req_clear_cycles", 32'(n), 32'd64);
        check("req_rd_zero_while_busy", 32'(bad), 32'd0);
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        for (int i = 0; i < 22; i++) begin
            a = ADDR_W'(3 * i);
            drive(1'b0, '0, '0, {a + 6'd2, a + 6'd1, a}, 1'b0);
            tick();
            check($sformatf("post_clear_sweep%0d", i), 32'(rd_data), 32'd0);
        end

        // Reset in the middle of a clear restarts the sweep
        for (int i = 40; i < 46; i++) begin
            drive(1'b1, ADDR_W'(i), 4'hB, '0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();
        check("midclr_busy_rise", 32'(busy), 32'd1);
        clear_req = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        #1;
        check("midclr_rst_busy", 32'(busy), 32'd1);
        check("midclr_rst_rd", 32'(rd_data), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        count_busy(n, bad);
        check("midclr_restart_cycles", 32'(n), 32'd64);
        drive(1'b0, '0, '0, {6'd45, 6'd41, 6'd40}, 1'b0);
        tick();
        check("midclr_cleared_words", 32'(rd_data), 32'd0);
        drive(1'b1, 6'd9, 4'hF, '0, 1'b0);
        tick();
        drive(1'b0, '0, '0, {6'd9, 6'd0, 6'd9}, 1'b0);
        tick();
        check("post_reset_write", 32'(rd_data), 32'hF0F);

`ifdef DRAM_MULTIPORT_PARITY_EN
        // Parity: corrupt a stored word, clean word and bypass report 0
        drive(1'b1, 6'd4, 4'h6, '0, 1'b0);
        tick();
        drive(1'b1, 6'd8, 4'h9, '0, 1'b0);
        tick();
        drive(1'b0, '0, '0, {6'd4, 6'd8, 6'd4}, 1'b0);
        tick();
        check("par_clean", 32'(rd_perr), 32'd0);
        dut.mem_q[4][0] = ~dut.mem_q[4][0];
        tick();
        check("par_err_flag", 32'(rd_perr), 32'b101);
        check("par_err_data", 32'(rd_data), 32'h797);
        drive(1'b1, 6'd4, 4'h6, {6'd4, 6'd8, 6'd4}, 1'b0);
        tick();
        check("par_bypass", 32'(rd_perr), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_multiport.md
Name: dram_multiport

Overview:
- Parametrised successor to the single quad-port 64x1 distributed-RAM test block.
- One synchronous write port and NUM_RD independent read ports with registered outputs.
- Supports arbitrary word width and depth, with write-first bypass on address collision.
- A built-in clear sequencer initialises every word on reset or on request, because the LUT-RAM array itself cannot be reset.
- Used as a DRAM inference/packing test top and as a small register-file primitive in fabric designs.

Parameters:
- DATA_W, 4, bits per word.
- ADDR_W, 6, address bits; depth = 2**ADDR_W.
- NUM_RD, 3, number of read ports (1..8).
- CLEAR_VAL, {DATA_W{1'b0}}, value written to every word by the clear sequence.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe; ignored while busy.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port k = bits [k*DATA_W +: DATA_W].
- clear_req  in  1  single-cycle pulse requesting re-initialisation.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (async assert): FSM enters CLEAR, clear address counter = 0, busy = 1, all rd_data = 0. The array contents are not reset directly.
- FSM states are IDLE and CLEAR.
- CLEAR:
  - Each cycle writes CLEAR_VAL to the counter address, then increments the counter.
  - On the cycle the counter equals 2**ADDR_W-1, the last word is written and the FSM goes to IDLE.
  - busy is low from the next cycle onward.
  - The clear therefore takes exactly 2**ADDR_W cycles after reset deassertion.
- IDLE:
  - clear_req=1 moves the FSM to CLEAR on the next edge, with the counter at 0.
  - Any wr_en in that same cycle is still performed; the clear then overwrites it.
- While busy:
  - wr_en is ignored.
  - clear_req is ignored; the sequence is not restarted.
  - All rd_data registers are held at 0.
- Write: when wr_en=1 and busy=0, mem[wr_addr] <= wr_data at the edge.
- Read: rd_data[k] <= mem[rd_addr[k]] at each edge (1-cycle latency, asynchronous LUT read then register).
- Collision, write-first: if wr_en=1, busy=0 and rd_addr[k]==wr_addr in the same cycle, rd_data[k] gets wr_data on that edge. This applies to every colliding port independently.
- Multiple read ports may present the same address with no restriction.
- Reset asserted mid-clear or mid-operation: everything returns immediately to the reset state, and the clear restarts from address 0 after deassertion.
- Addresses wrap naturally within ADDR_W bits; no out-of-range addresses are possible.

Optional Feature:
- Macro DRAM_MULTIPORT_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed at write time and also written by the clear sequence.
  - Adds output rd_perr [NUM_RD-1:0], registered alongside rd_data. Bit k = 1 when the stored parity mismatches the stored data for port k's read.
  - Bypass reads always report 0.
  - Reset value is 0; held at 0 while busy.
- When undefined: no parity storage and no rd_perr port.

Decomposition:
- Package dram_multiport_pkg holds:
  - the state enum (ST_IDLE, ST_CLEAR);
  - a function par_even(data) used by the parity option.
- Sub-module dram_multiport_clear_seq holds the FSM and address counter. It outputs busy, clr_we and clr_addr.
- The top level keeps the array, write mux (clear vs user), read registers and bypass logic.

Test Plan:
- Reset, then hold rst low for 64 cycles: busy=1 for exactly 64 cycles, then 0. Afterwards, reads at addresses 0, 31 and 63 on all ports return 0 with rd_data=0 throughout busy.
- Write 0xA to address 5 and 0x3 to address 63. Next cycle set rd_addr={63,5,5}: one cycle later rd_data={0x3,0xA,0xA}.
- Same-cycle wr_en=1, wr_addr=12, wr_data=0x7 with rd_addr[0]=12 and rd_addr[1]=13 (mem[13]=0x1): next cycle rd_data[0]=0x7 and rd_data[1]=0x1.
- With data written at addresses 0..63, pulse clear_req: busy rises the next cycle for 64 cycles. wr_en during busy (addr 9, 0xF) has no effect; afterwards every address reads CLEAR_VAL.
- Assert rst mid-clear when the counter is at 30: busy stays high, and after deassertion a full 64-cycle clear occurs.
- Parity build: force-flip a stored data bit at address 4 via a hierarchical write, then read address 4: rd_perr[k]=1 on the reading port. A clean address gives rd_perr=0.
